// File: rtl/enc_dec_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enc_dec_ctrl : APB register block and launch/wait/capture sequencer for the
// encode/decode datapath. Optional watchdog: ENC_DEC_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module enc_dec_ctrl #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic                       dp_start,
  output logic [1:0]                 dp_mode,
  output logic [DATA_WIDTH-1:0]      dp_data,
  output logic [1:0]                 dp_width,
  output logic [DATA_WIDTH-1:0]      dp_noise,
  input  logic                       dp_done,
  input  logic [DATA_WIDTH-1:0]      dp_data_out,
  input  logic [1:0]                 dp_nof,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [1:0]                 num_of_errors,
  output logic                       operation_done,
  output logic                       busy
);

  localparam logic [1:0] ADDR_CTRL  = 2'b00;
  localparam logic [1:0] ADDR_DATA  = 2'b01;
  localparam logic [1:0] ADDR_WIDTH = 2'b10;
  localparam logic [1:0] ADDR_NOISE = 2'b11;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [AMBA_WORD-1:0] r_ctrl, r_data_in, r_cw_width, r_noise;
  logic [1:0]           w_sel;
  logic                 w_wr, w_rd, w_idle, w_wr_ok, w_launch, w_timeout, w_unused;

  assign w_sel    = PADDR[3:2];
  assign w_wr     = PSEL & PENABLE & PWRITE;
  assign w_rd     = PSEL & PENABLE & ~PWRITE;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_wr_ok  = w_wr & w_idle;
  assign w_launch = w_wr_ok & (w_sel == ADDR_CTRL) & (PWDATA[1:0] != MODE_RSVD);
  assign busy     = ~w_idle;
  assign PREADY   = 1'b1;
  assign w_unused = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0], TIMEOUT_CYCLES};

  // A reserved-mode CTRL write is still stored; only the launch is refused.
  assign PSLVERR = w_wr & (busy | ((w_sel == ADDR_CTRL) & (PWDATA[1:0] == MODE_RSVD)));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ctrl     <= '0;
      r_data_in  <= '0;
      r_cw_width <= '0;
      r_noise    <= '0;
    end else if (w_wr_ok) begin
      case (w_sel)
        ADDR_CTRL:  r_ctrl     <= PWDATA;
        ADDR_DATA:  r_data_in  <= PWDATA;
        ADDR_WIDTH: r_cw_width <= PWDATA;
        ADDR_NOISE: r_noise    <= PWDATA;
        default:    r_ctrl     <= r_ctrl;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    if (w_rd) begin
      case (w_sel)
        ADDR_CTRL:  PRDATA = r_ctrl;
        ADDR_DATA:  PRDATA = r_data_in;
        ADDR_WIDTH: PRDATA = r_cw_width;
        ADDR_NOISE: PRDATA = r_noise;
        default:    PRDATA = '0;
      endcase
    end
  end

`ifdef ENC_DEC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wait_cnt <= '0;
    end else if (w_launch) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Counter holds the index of the current WAIT cycle; the last allowed one ends the wait.
  assign w_timeout = (r_state == ST_WAIT) & ~dp_done &
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    dp_start       = 1'b0;
    operation_done = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_launch) w_state_nxt = ST_LAUNCH;
      ST_LAUNCH: begin
        dp_start    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT:   if (dp_done || w_timeout) w_state_nxt = ST_DONE;
      ST_DONE: begin
        operation_done = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Mode comes straight from the committing write; the other inputs are already stable.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dp_mode  <= '0;
      dp_data  <= '0;
      dp_width <= '0;
      dp_noise <= '0;
    end else if (w_launch) begin
      dp_mode  <= PWDATA[1:0];
      dp_data  <= r_data_in[DATA_WIDTH-1:0];
      dp_width <= r_cw_width[1:0];
      dp_noise <= r_noise[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      data_out      <= '0;
      num_of_errors <= '0;
    end else if (r_state == ST_WAIT) begin
      if (dp_done) begin
        data_out      <= dp_data_out;
        num_of_errors <= dp_nof;
      end else if (w_timeout) begin
        data_out      <= '0;
        num_of_errors <= 2'b11;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enc_dec_ctrl.sv
`default_nettype none
// Self-checking bench for enc_dec_ctrl: directed scenarios plus randomized
// operations scored against a register/latency model of the controller.
module tb_enc_dec_ctrl;
  localparam int AW = 20;
  localparam int DW = 32;

  logic          PCLK = 1'b0, PRESETn = 1'b0;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic          dp_start, dp_done = 1'b0;
  logic [1:0]    dp_mode, dp_width, dp_nof = 2'b00, num_of_errors;
  logic [DW-1:0] dp_data, dp_noise, dp_data_out = '0, data_out;
  logic          operation_done, busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_reg [4];

  enc_dec_ctrl #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(32), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dp_start(dp_start), .dp_mode(dp_mode), .dp_data(dp_data), .dp_width(dp_width),
    .dp_noise(dp_noise), .dp_done(dp_done), .dp_data_out(dp_data_out), .dp_nof(dp_nof),
    .data_out(data_out), .num_of_errors(num_of_errors), .operation_done(operation_done),
    .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  // Returns one ns after the commit edge, i.e. inside the LAUNCH cycle if launched.
  task automatic apb_write(input logic [1:0] sel, input logic [31:0] data, output logic slverr);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = AW'($urandom); PADDR[3:2] = sel; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    slverr = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = $urandom;
  endtask

  task automatic apb_read(input logic [1:0] sel, output logic [31:0] data, output logic slverr);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = AW'($urandom); PADDR[3:2] = sel;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    data = PRDATA; slverr = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic e; logic [31:0] d;
    @(negedge PCLK);
    checks++;
    if ({PRDATA, PSLVERR, dp_start, dp_mode, dp_data, dp_width, dp_noise, data_out,
         num_of_errors, operation_done, busy} !== '0 || PREADY !== 1'b1) begin
      errors++; $display("FAIL reset_outputs: busy=%b dout=%h pready=%b expected zeros/pready=1", busy, data_out, PREADY);
    end
    PRESETn = 1'b1;
    apb_write(2'd1, 32'hDEAD_BEEF, e);
    apb_read(2'd1, d, e);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pre_reset_read: got %h exp DEADBEEF", d); end
    @(negedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    checks++;
    if ({PRDATA, PSLVERR, dp_start, busy, data_out, operation_done} !== '0) begin
      errors++; $display("FAIL async_reset: prdata=%h busy=%b expected 0", PRDATA, busy);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    apb_read(2'd1, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL reset_reg_clear: got %h/%b exp 0/0", d, e); end
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
  endtask

  task automatic test_encode();
    logic e;
    apb_write(2'd1, 32'h0000_00A5, e);
    apb_write(2'd2, 32'h0, e);
    apb_write(2'd3, 32'h0, e);
    apb_write(2'd0, 32'h0, e);
    m_reg[0] = 0; m_reg[1] = 32'hA5; m_reg[2] = 0; m_reg[3] = 0;
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL enc_slverr: got %b exp 0", e); end
    @(negedge PCLK);
    checks++;
    if ({dp_start, busy, dp_mode, dp_data} !== {1'b1, 1'b1, 2'b00, 32'hA5}) begin
      errors++; $display("FAIL enc_launch: start=%b busy=%b mode=%b data=%h exp 1 1 00 a5", dp_start, busy, dp_mode, dp_data);
    end
    @(posedge PCLK); #1;
    dp_done = 1'b1; dp_data_out = 32'h1234; dp_nof = 2'b00;
    @(posedge PCLK); #1;
    dp_done = 1'b0; dp_data_out = 32'hBAD0_0BAD;
    @(negedge PCLK);
    checks++;
    if ({operation_done, data_out, num_of_errors} !== {1'b1, 32'h1234, 2'b00}) begin
      errors++; $display("FAIL enc_result: done=%b dout=%h nof=%b exp 1 1234 00", operation_done, data_out, num_of_errors);
    end
    @(negedge PCLK);
    checks++;
    if ({operation_done, busy, data_out} !== {1'b0, 1'b0, 32'h1234}) begin
      errors++; $display("FAIL enc_one_cycle: done=%b busy=%b dout=%h exp 0 0 1234", operation_done, busy, data_out);
    end
  endtask

  task automatic test_decode_busy();
    logic e; logic [31:0] d;
    apb_write(2'd3, 32'h3, e);
    apb_write(2'd0, 32'h1, e);
    m_reg[3] = 32'h3; m_reg[0] = 32'h1;
    @(negedge PCLK);
    checks++;
    if ({dp_start, dp_mode, dp_noise, dp_data} !== {1'b1, 2'b01, 32'h3, 32'hA5}) begin
      errors++; $display("FAIL dec_launch: start=%b mode=%b noise=%h data=%h", dp_start, dp_mode, dp_noise, dp_data);
    end
    apb_write(2'd1, 32'hFFFF, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL busy_write_err: got %b exp 1", e); end
    apb_read(2'd1, d, e);
    checks++;
    if (d !== 32'hA5 || e !== 1'b0) begin errors++; $display("FAIL busy_read: got %h/%b exp a5/0", d, e); end
    dp_done = 1'b1; dp_data_out = 32'h0F0F_0F01; dp_nof = 2'b10;
    @(posedge PCLK); #1;
    dp_done = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({operation_done, num_of_errors, data_out} !== {1'b1, 2'b10, 32'h0F0F_0F01}) begin
      errors++; $display("FAIL dec_result: done=%b nof=%b dout=%h exp 1 10 0f0f0f01", operation_done, num_of_errors, data_out);
    end
  endtask

  task automatic test_reserved();
    logic e; logic [31:0] d; logic seen;
    apb_write(2'd0, 32'h3, e);
    m_reg[0] = 32'h3;
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL rsvd_slverr: got %b exp 1", e); end
    seen = 1'b0;
    repeat (5) begin @(negedge PCLK); seen |= dp_start | busy; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rsvd_no_launch: got %b exp 0", seen); end
    apb_read(2'd0, d, e);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL rsvd_readback: got %h exp 3", d); end
  endtask

  task automatic test_launch_ignore();
    logic e; logic seen;
    apb_write(2'd0, 32'h2, e);
    m_reg[0] = 32'h2;
    dp_done = 1'b1; dp_data_out = 32'h5555_0000; dp_nof = 2'b01;
    @(posedge PCLK); #1;
    dp_done = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge PCLK); seen |= operation_done | ~busy; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL launch_done_ignored: got %b exp 0", seen); end
    @(posedge PCLK); #1;
    dp_done = 1'b1; dp_data_out = 32'h0000_7777; dp_nof = 2'b00;
    @(posedge PCLK); #1;
    dp_done = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({operation_done, data_out} !== {1'b1, 32'h7777}) begin
      errors++; $display("FAIL ignore_then_done: done=%b dout=%h exp 1 7777", operation_done, data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    apb_write(2'd0, 32'h0, e);
    m_reg[0] = 0;
    @(posedge PCLK); #1;
    dp_done = 1'b1; dp_data_out = 32'hAAAA_0001; dp_nof = 2'b01;
    @(posedge PCLK); #1;
    dp_done = 1'b0;
    // Setup phase overlaps the completion cycle so the access lands right after it.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = '0; PWDATA = 32'h1;
    @(negedge PCLK);
    checks++;
    if ({operation_done, data_out} !== {1'b1, 32'hAAAA_0001}) begin
      errors++; $display("FAIL b2b_min_latency: done=%b dout=%h exp 1 aaaa0001", operation_done, data_out);
    end
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    checks++;
    if (PSLVERR !== 1'b0) begin errors++; $display("FAIL b2b_accept_err: got %b exp 0", PSLVERR); end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    m_reg[0] = 32'h1;
    @(negedge PCLK);
    checks++;
    if ({dp_start, dp_mode} !== {1'b1, 2'b01}) begin
      errors++; $display("FAIL b2b_relaunch: start=%b mode=%b exp 1 01", dp_start, dp_mode);
    end
    @(posedge PCLK); #1;
    dp_done = 1'b1; dp_data_out = 32'hAAAA_0002; dp_nof = 2'b00;
    @(posedge PCLK); #1;
    dp_done = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({operation_done, data_out} !== {1'b1, 32'hAAAA_0002}) begin
      errors++; $display("FAIL b2b_second: done=%b dout=%h exp 1 aaaa0002", operation_done, data_out);
    end
  endtask

  task automatic test_random_ops();
    logic e; logic [31:0] d, wd, rdat; logic [1:0] sel, mode, rnof;
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(0, 3)) begin
        sel = 2'($urandom_range(1, 3)); wd = $urandom;
        apb_write(sel, wd, e);
        m_reg[sel] = wd;
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL rnd_cfg_err it%0d: got %b exp 0", it, e); end
      end
      sel = 2'($urandom);
      apb_read(sel, d, e);
      checks++;
      if (d !== m_reg[sel]) begin errors++; $display("FAIL rnd_read it%0d reg%0d: got %h exp %h", it, sel, d, m_reg[sel]); end
      wd = $urandom; mode = wd[1:0];
      apb_write(2'd0, wd, e);
      m_reg[0] = wd;
      checks++;
      if (e !== (mode == 2'b11)) begin errors++; $display("FAIL rnd_ctrl_err it%0d: got %b exp %b", it, e, mode == 2'b11); end
      @(negedge PCLK);
      if (mode == 2'b11) begin
        checks++;
        if ({busy, dp_start} !== 2'b00) begin errors++; $display("FAIL rnd_rsvd it%0d: busy=%b start=%b exp 0 0", it, busy, dp_start); end
        continue;
      end
      checks++;
      if ({dp_start, dp_mode, dp_data, dp_width, dp_noise} !== {1'b1, mode, m_reg[1], m_reg[2][1:0], m_reg[3]}) begin
        errors++; $display("FAIL rnd_launch it%0d: start=%b mode=%b data=%h w=%b noise=%h exp 1 %b %h %b %h",
                          it, dp_start, dp_mode, dp_data, dp_width, dp_noise, mode, m_reg[1], m_reg[2][1:0], m_reg[3]);
      end
      if ($urandom_range(0, 1) == 1) begin
        sel = 2'($urandom);
        apb_write(sel, $urandom, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL rnd_busy_err it%0d: got %b exp 1", it, e); end
        apb_read(sel, d, e);
        checks++;
        if (d !== m_reg[sel] || e !== 1'b0) begin errors++; $display("FAIL rnd_busy_keep it%0d: got %h/%b exp %h/0", it, d, e, m_reg[sel]); end
      end
      @(posedge PCLK); #1;
      repeat ($urandom_range(0, 4)) begin @(posedge PCLK); #1; end
      checks++;
      if ({busy, operation_done} !== 2'b10) begin errors++; $display("FAIL rnd_wait it%0d: busy=%b done=%b exp 1 0", it, busy, operation_done); end
      rdat = $urandom; rnof = 2'($urandom_range(0, 2));
      dp_done = 1'b1; dp_data_out = rdat; dp_nof = rnof;
      @(posedge PCLK); #1;
      dp_done = 1'b0; dp_data_out = $urandom; dp_nof = 2'($urandom);
      @(negedge PCLK);
      checks++;
      if ({operation_done, data_out, num_of_errors} !== {1'b1, rdat, rnof}) begin
        errors++; $display("FAIL rnd_result it%0d: done=%b dout=%h nof=%b exp 1 %h %b", it, operation_done, data_out, num_of_errors, rdat, rnof);
      end
      @(negedge PCLK);
      checks++;
      if ({operation_done, busy, data_out} !== {1'b0, 1'b0, rdat}) begin
        errors++; $display("FAIL rnd_hold it%0d: done=%b busy=%b dout=%h exp 0 0 %h", it, operation_done, busy, data_out, rdat);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic e; logic [31:0] d; logic seen;
    apb_write(2'd0, 32'h0, e);
    @(posedge PCLK); #1;
    @(negedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    checks++;
    if ({busy, data_out, dp_start, operation_done} !== '0) begin
      errors++; $display("FAIL midop_reset: busy=%b dout=%h exp 0 0", busy, data_out);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    @(posedge PCLK); #1;
    dp_done = 1'b1; dp_data_out = 32'h1111_2222;
    @(posedge PCLK); #1;
    dp_done = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge PCLK); seen |= operation_done | busy | (|data_out); end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midop_discard: got %b exp 0", seen); end
    apb_read(2'd0, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midop_ctrl_clear: got %h exp 0", d); end
  endtask

`ifdef ENC_DEC_TIMEOUT_EN
  task automatic test_timeout();
    logic e; int n;
    apb_write(2'd0, 32'h2, e);
    m_reg[0] = 32'h2;
    @(posedge PCLK); #1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK);
      if (operation_done) break;
      n++;
    end
    checks++;
    if (n !== 64 || data_out !== 32'h0 || num_of_errors !== 2'b11) begin
      errors++; $display("FAIL timeout: cycles=%0d dout=%h nof=%b exp 64 0 11", n, data_out, num_of_errors);
    end
    @(negedge PCLK);
  endtask
`else
  task automatic test_timeout();
    logic e; logic seen;
    apb_write(2'd0, 32'h1, e);
    m_reg[0] = 32'h1;
    seen = 1'b0;
    repeat (100) begin @(negedge PCLK); seen |= operation_done | ~busy; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL no_timeout_hold: got %b exp 0", seen); end
    @(posedge PCLK); #1;
    dp_done = 1'b1; dp_data_out = 32'h0000_0ABC; dp_nof = 2'b01;
    @(posedge PCLK); #1;
    dp_done = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({operation_done, data_out, num_of_errors} !== {1'b1, 32'hABC, 2'b01}) begin
      errors++; $display("FAIL no_timeout_done: done=%b dout=%h nof=%b exp 1 abc 01", operation_done, data_out, num_of_errors);
    end
    @(negedge PCLK);
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    test_reset();
    test_encode();
    test_decode_busy();
    test_reserved();
    test_launch_ignore();
    test_back_to_back();
    test_random_ops();
    test_timeout();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
